// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory slave with a programmable
// response delay, used to exercise the CPU against slow memory.
//
// Handshake rules (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. The request channel is only ready in IDLE. Once
// resp_valid rises, resp_valid/resp_rdata/resp_err hold steady until an edge
// with resp_ready=1 consumes them. Only one transaction is ever in flight.
//
// Timing: a request accepted at edge k spends LATENCY+1 cycles in WAIT.
// resp_valid rises at edge k+LATENCY+1, so each transaction takes at least
// LATENCY+2 cycles. The store commit and the load read both happen on the
// edge that enters RESP.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t state;
  state_t next_state;

  logic [3:0]     count;
  logic           cap_write;
  logic [31:0]    cap_addr;
  logic [31:0]    cap_wdata;
  logic [31:0]    rdata_q;
  logic           err_q;
  logic           cap_err;
  logic           wait_done;
  logic           enter_resp;
  logic [IDXW-1:0] cap_idx;

  logic [31:0] mem [DEPTH_WORDS];

  // The word index is the full byte address shifted right by two. The
  // comparison against DEPTH_WORDS uses all 32 bits, so high addresses are
  // flagged rather than wrapped. cap_idx is only used once cap_err is clear.
  assign cap_idx    = cap_addr[IDXW+1:2];
  assign cap_err    = (cap_addr[1:0] != 2'b00) || ((cap_addr >> 2) >= 32'(DEPTH_WORDS));
  assign wait_done  = (count == 4'(LATENCY));
  assign enter_resp = (state == WAIT) && wait_done;

  assign req_ready  = !reset && (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state;

  // Next-state logic: accept in IDLE, count out the delay in WAIT, and hold
  // the response in RESP until the CPU consumes it.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid)  next_state = WAIT;
      WAIT:    if (wait_done)  next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register, request capture, wait counter and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            count     <= 4'd0;
          end
        end
        WAIT: begin
          if (!wait_done) begin
            count <= count + 4'd1;
          end else if (cap_err) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end else if (cap_write) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
          end else begin
            rdata_q <= mem[cap_idx];
            err_q   <= 1'b0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            count   <= 4'd0;
          end
        end
        default: begin
          count <= 4'd0;
        end
      endcase
    end
  end

  // Store commit on the edge entering RESP. The array is not reset, and a
  // reset on that edge wins so an uncommitted store never lands.
  always_ff @(posedge clock) begin
    if (!reset && enter_resp && cap_write && !cap_err) begin
      mem[cap_idx] <= cap_wdata;
    end
  end

endmodule
